// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator: default sizes, mode type, select-width helper.
// Center-aligned mode is compiled in only when PWM_CENTER_ALIGN_EN is defined.
`timescale 1ns/1ps
package pwm_pkg;

  localparam int PWM_DEFAULT_CH = 4;
  localparam int PWM_DEFAULT_W  = 8;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  // Channel-select width; a single channel still needs a 1-bit select port.
  function automatic int pwm_chw(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM compare channel: duty staging/active registers, compare against the shared counter,
// polarity inversion and registered output.
`timescale 1ns/1ps
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int W = PWM_DEFAULT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         load_act,
  input  logic         duty_wr,
  input  logic [W-1:0] duty_data,
  input  logic [W-1:0] cnt,
  input  logic         polarity,
  output logic         pwm_out
);

  logic [W-1:0] duty_stage;
  logic [W-1:0] duty_act;
  logic         raw;

  assign raw = (cnt < duty_act);

  // duty_act copies the register value of duty_stage, so a write landing on the
  // boundary edge is deferred to the following period.
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_stage <= '0;
      duty_act   <= '0;
      pwm_out    <= 1'b0;
    end else begin
      if (duty_wr) begin
        duty_stage <= duty_data;
      end
      if (load_act) begin
        duty_act <= duty_stage;
      end
      pwm_out <= enable ? (raw ^ polarity) : polarity;
    end
  end

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM top: shared period counter and boundary logic feeding CH compare channels.
// Define PWM_CENTER_ALIGN_EN to add the center_mode port and the up/down counting mode.
`timescale 1ns/1ps
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int CH  = PWM_DEFAULT_CH,
  parameter int W   = PWM_DEFAULT_W,
  parameter int CHW = pwm_chw(CH)
) (
  input  logic           clk,
  input  logic           reset,
`ifdef PWM_CENTER_ALIGN_EN
  input  logic           center_mode,
`endif
  input  logic           enable,
  input  logic [W-1:0]   period,
  input  logic           duty_wr,
  input  logic [CHW-1:0] duty_ch,
  input  logic [W-1:0]   duty_data,
  input  logic [CH-1:0]  polarity,
  output logic [CH-1:0]  pwm_out,
  output logic           period_start,
  output logic [W-1:0]   cnt
);

  logic [W-1:0] period_act;
  logic [W-1:0] cnt_next;
  logic         boundary;
  logic         load_act;

`ifdef PWM_CENTER_ALIGN_EN
  pwm_mode_e mode_act;
  logic      dir_down;
  logic      dir_down_next;

  // Center mode: 0..P up, P-1..1 down; the 1->0 turn while counting down closes the period.
  always_comb begin
    boundary      = 1'b0;
    cnt_next      = cnt;
    dir_down_next = dir_down;
    if (mode_act == PWM_CENTER) begin
      boundary = (period_act == '0) ||
                 ((cnt == W'(1)) && (dir_down || (period_act == W'(1))));
      if (boundary) begin
        cnt_next      = '0;
        dir_down_next = 1'b0;
      end else if (dir_down) begin
        cnt_next = cnt - W'(1);
      end else if (cnt == period_act) begin
        cnt_next      = cnt - W'(1);
        dir_down_next = 1'b1;
      end else begin
        cnt_next = cnt + W'(1);
      end
    end else begin
      boundary = (cnt == period_act);
      cnt_next = boundary ? '0 : cnt + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_act <= PWM_EDGE;
      dir_down <= 1'b0;
    end else begin
      if (load_act) begin
        mode_act <= center_mode ? PWM_CENTER : PWM_EDGE;
      end
      dir_down <= enable ? dir_down_next : 1'b0;
    end
  end
`else
  always_comb begin
    boundary = (cnt == period_act);
    cnt_next = boundary ? '0 : cnt + W'(1);
  end
`endif

  // While disabled the active registers track staging so re-enable starts fresh.
  assign load_act = !enable || (enable && boundary);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      period_act   <= '0;
      period_start <= 1'b0;
    end else begin
      if (load_act) begin
        period_act <= period;
      end
      period_start <= enable && (cnt == '0);
      cnt          <= enable ? cnt_next : '0;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic ch_wr;
    assign ch_wr = duty_wr && (duty_ch == CHW'(i));

    pwm_channel #(
      .W (W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .load_act  (load_act),
      .duty_wr   (ch_wr),
      .duty_data (duty_data),
      .cnt       (cnt),
      .polarity  (polarity[i]),
      .pwm_out   (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel: driver pushes hand-derived per-cycle expectations,
// a negedge monitor pops and compares them against pwm_out/cnt/period_start.
`timescale 1ns/1ps
module tb_pwm_multi_channel;
  import pwm_pkg::*;

  localparam int CH  = 4;
  localparam int W   = 8;
  localparam int CHW = 2;
  localparam int EW  = 14;  // {check, pwm_out[3:0], cnt[7:0], period_start}

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic [W-1:0]   period;
  logic           duty_wr;
  logic [CHW-1:0] duty_ch;
  logic [W-1:0]   duty_data;
  logic [CH-1:0]  polarity;
  logic [CH-1:0]  pwm_out;
  logic           period_start;
  logic [W-1:0]   cnt;
`ifdef PWM_CENTER_ALIGN_EN
  logic           center_mode;
`endif

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pwm_multi_channel #(
    .CH (CH),
    .W  (W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef PWM_CENTER_ALIGN_EN
    .center_mode  (center_mode),
`endif
    .enable       (enable),
    .period       (period),
    .duty_wr      (duty_wr),
    .duty_ch      (duty_ch),
    .duty_data    (duty_data),
    .polarity     (polarity),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .cnt          (cnt)
  );

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  function automatic logic [EW-1:0] mk(input int cnt_n, input logic [3:0] pwm, input logic ps);
    logic [W-1:0] c8;
    c8 = W'(cnt_n);
    return {1'b1, pwm, c8, ps};
  endfunction

  // One clock; the expectation describes outputs right after this edge.
  task automatic cyc(input logic [EW-1:0] e);
    @(posedge clk);
    #1;
    exp_q.push_back(e);
  endtask

  // Edge mode, period 10: counter value c before the edge, ch0 duty d0, fixed levels for ch3..ch1.
  task automatic edge_step(input int c, input int d0, input logic [2:0] up);
    logic b;
    b = (c < d0);
    cyc(mk((c + 1) % 10, {up, b}, (c == 0)));
  endtask

  // Duty write while disabled: outputs sit at the polarity level 4'b1000.
  task automatic write_disabled(input int ch, input int val);
    duty_wr   = 1'b1;
    duty_ch   = CHW'(ch);
    duty_data = W'(val);
    cyc(mk(0, 4'b1000, 1'b0));
    duty_wr   = 1'b0;
  endtask

  task automatic set_write(input int ch, input int val);
    duty_wr   = 1'b1;
    duty_ch   = CHW'(ch);
    duty_data = W'(val);
  endtask

`ifdef PWM_CENTER_ALIGN_EN
  function automatic int tri_seq(input int j);
    return (j <= 8) ? j : 16 - j;
  endfunction
`endif

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[EW-1]) begin
          n_checks++;
          if (pwm_out === e[12:9] && cnt === e[8:1] && period_start === e[0]) begin
            n_pass++;
          end else begin
            $display("FAIL cycle_check t=%0t: got pwm_out=%b cnt=%0d period_start=%b, required pwm_out=%b cnt=%0d period_start=%b",
                     $time, pwm_out, cnt, period_start, e[12:9], e[8:1], e[0]);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    period    = '0;
    duty_wr   = 1'b0;
    duty_ch   = '0;
    duty_data = '0;
    polarity  = '0;
`ifdef PWM_CENTER_ALIGN_EN
    center_mode = 1'b0;
`endif
    cyc(mk(0, 4'b0000, 1'b0));
    cyc(mk(0, 4'b0000, 1'b0));

    // Configure while disabled: ch0=3, ch1=0, ch2=10 (>period), ch3=0 with inverted polarity.
    reset    = 1'b0;
    period   = W'(9);
    polarity = 4'b1000;
    write_disabled(0, 3);
    write_disabled(1, 0);
    write_disabled(2, 10);
    write_disabled(3, 0);
    cyc(mk(0, 4'b1000, 1'b0));
    enable = 1'b1;

    // Basic duty and extremes: three full periods.
    for (int k = 0; k < 30; k++) edge_step(k % 10, 3, 3'b110);

    // Mid-period write (cnt=4) and boundary-cycle write (cnt=9).
    for (int k = 30; k < 70; k++) begin
      if (k == 34) set_write(0, 7);
      if (k == 49) set_write(0, 2);
      if (k == 35 || k == 50) duty_wr = 1'b0;
      edge_step(k % 10, (k < 40) ? 3 : ((k < 60) ? 7 : 2), 3'b110);
    end

    // Enable drop at cnt=6, stage a new duty while idle, then re-enable.
    for (int k = 70; k < 76; k++) edge_step(k % 10, 2, 3'b110);
    enable = 1'b0;
    cyc(mk(0, 4'b1000, 1'b0));
    write_disabled(0, 5);
    cyc(mk(0, 4'b1000, 1'b0));
    cyc(mk(0, 4'b1000, 1'b0));
    enable = 1'b1;
    for (int j = 0; j < 15; j++) edge_step(j % 10, 5, 3'b110);

    // Reset at cnt=5 for one cycle.
    reset = 1'b1;
    cyc(mk(0, 4'b0000, 1'b0));
    reset = 1'b0;
    // period_act is 0 after reset, so this first edge is a boundary that reloads period.
    cyc(mk(0, 4'b1000, 1'b1));
    for (int j = 0; j < 22; j++) begin
      if (j == 1) set_write(0, 4);
      if (j == 2) duty_wr = 1'b0;
      edge_step(j % 10, (j < 10) ? 0 : 4, 3'b100);
    end

    // Lower period to 0 mid-period: current period completes, then cnt pins at 0.
    period = '0;
    for (int j = 22; j < 30; j++) edge_step(j % 10, 4, 3'b100);
    for (int j = 0; j < 5; j++) cyc(mk(0, 4'b1001, 1'b1));

`ifdef PWM_CENTER_ALIGN_EN
    enable      = 1'b0;
    period      = W'(8);
    center_mode = 1'b1;
    write_disabled(0, 3);
    cyc(mk(0, 4'b1000, 1'b0));
    enable = 1'b1;
    for (int j = 0; j < 32; j++) begin
      int  s;
      logic b;
      s = tri_seq(j % 16);
      b = (s < 3);
      cyc(mk(tri_seq((j + 1) % 16), {3'b100, b}, (s == 0)));
    end
`endif

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL queue_drain: got %0d entries left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
